// File: rtl/turbo_frame_ctrl_if.sv
// Stream bundle for turbo_frame_ctrl: frame config, info-bit input, triplet output.
interface turbo_frame_ctrl_if #(parameter int IDX_W = 7);
  logic             start;
  logic [IDX_W-1:0] cfg_size;
  logic             in_valid, in_ready, in_bit;
  logic             out_valid, out_ready;
  logic             out_sys, out_p1, out_p2, out_tail, out_last;
  logic             busy, err_size;

  modport master (output start, cfg_size, in_valid, in_bit, out_ready,
                  input  in_ready, out_valid, out_sys, out_p1, out_p2,
                         out_tail, out_last, busy, err_size);
  modport slave  (input  start, cfg_size, in_valid, in_bit, out_ready,
                  output in_ready, out_valid, out_sys, out_p1, out_p2,
                         out_tail, out_last, busy, err_size);
endinterface

// File: rtl/turbo_frame_ctrl.sv
// Turbo encoder frame sequencer: buffers K bits, runs two 4-state RSC encoders, streams triplets.
// Define TURBO_CTRL_TERM_EN to append the 4-triplet trellis termination tail.
package rsc_lib;
  // Even positions first, then odd: a permutation for every K >= 2.
  function automatic int interleave_index(input int i, input int k);
    int h;
    h = (k + 1) / 2;
    return (i < h) ? 2 * i : 2 * (i - h) + 1;
  endfunction
endpackage

module turbo_frame_ctrl #(
  parameter int MAX_K = 64,
  parameter int IDX_W = $clog2(MAX_K + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  turbo_frame_ctrl_if.slave bus
);
  localparam int AW = (MAX_K > 2) ? $clog2(MAX_K) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ENCODE, TAIL1, TAIL2} state_t;

  state_t           state;
  logic [MAX_K-1:0] buf_q;
  logic [IDX_W-1:0] k_q, wr_idx, idx;
  logic [1:0]       enc1, enc2;
  logic             done_q;
  logic             in_ready_q, out_valid_q, sys_q, p1_q, p2_q, tail_q, last_q, busy_q, err_q;

  logic [AW-1:0] pi_idx;
  logic          u1, u2, fb1, fb2;
  logic          t_sys, t_p1, t_p2, t_last;
  logic [1:0]    nxt1, nxt2;
  logic          active, step_end, gen, size_ok;

  always_comb begin
    pi_idx = AW'(rsc_lib::interleave_index(int'(idx), int'(k_q)));
    u1     = buf_q[idx[AW-1:0]];
    u2     = buf_q[pi_idx];
    fb1    = u1 ^ enc1[1] ^ enc1[0];
    fb2    = u2 ^ enc2[1] ^ enc2[0];
    t_sys  = 1'b0;
    t_p1   = 1'b0;
    t_p2   = 1'b0;
    nxt1   = enc1;
    nxt2   = enc2;
    case (state)
      ENCODE: begin
        t_sys = u1;
        t_p1  = fb1 ^ enc1[1];
        t_p2  = fb2 ^ enc2[1];
        nxt1  = {enc1[0], fb1};
        nxt2  = {enc2[0], fb2};
      end
      // Tail input u = s1^s0 forces fb=0, so parity reduces to s1.
      TAIL1: begin
        t_sys = enc1[1] ^ enc1[0];
        t_p1  = enc1[1];
        nxt1  = {enc1[0], 1'b0};
      end
      TAIL2: begin
        t_sys = enc2[1] ^ enc2[0];
        t_p2  = enc2[1];
        nxt2  = {enc2[0], 1'b0};
      end
      default: ;
    endcase
    active   = (state == ENCODE) || (state == TAIL1) || (state == TAIL2);
    step_end = (state == ENCODE) ? (idx == k_q - IDX_W'(1)) : (idx == IDX_W'(1));
    gen      = active && !done_q && (!out_valid_q || bus.out_ready);
    size_ok  = (bus.cfg_size >= IDX_W'(2)) && (bus.cfg_size <= IDX_W'(MAX_K));
`ifdef TURBO_CTRL_TERM_EN
    t_last   = (state == TAIL2) && step_end;
`else
    t_last   = (state == ENCODE) && step_end;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buf_q       <= '0;
      k_q         <= '0;
      wr_idx      <= '0;
      idx         <= '0;
      enc1        <= 2'b00;
      enc2        <= 2'b00;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sys_q       <= 1'b0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      tail_q      <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (gen) begin
        out_valid_q <= 1'b1;
        sys_q       <= t_sys;
        p1_q        <= t_p1;
        p2_q        <= t_p2;
        tail_q      <= (state != ENCODE);
        last_q      <= t_last;
        enc1        <= nxt1;
        enc2        <= nxt2;
        idx         <= step_end ? '0 : idx + IDX_W'(1);
        if (t_last) done_q <= 1'b1;
      end
      case (state)
        IDLE: if (bus.start) begin
          if (size_ok) begin
            state      <= LOAD;
            k_q        <= bus.cfg_size;
            wr_idx     <= '0;
            idx        <= '0;
            enc1       <= 2'b00;
            enc2       <= 2'b00;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        LOAD: if (bus.in_valid && in_ready_q) begin
          buf_q[wr_idx[AW-1:0]] <= bus.in_bit;
          if (wr_idx == k_q - IDX_W'(1)) begin
            state      <= ENCODE;
            in_ready_q <= 1'b0;
          end else begin
            wr_idx <= wr_idx + IDX_W'(1);
          end
        end
`ifdef TURBO_CTRL_TERM_EN
        ENCODE: if (gen && step_end) state <= TAIL1;
        TAIL1:  if (gen && step_end) state <= TAIL2;
`endif
        default: ;
      endcase
      // Frame ends on the handshake of the last triplet, not when it is generated.
      if (done_q && out_valid_q && bus.out_ready) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sys   = sys_q;
  assign bus.out_p1    = p1_q;
  assign bus.out_p2    = p2_q;
  assign bus.out_tail  = tail_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.err_size  = err_q;
endmodule
